// File: rtl/fpm.sv
// Registered 32x32 signed multiplier: radix-4 Booth partial products, carry-save
// reduction, final carry-propagate add; the low 32 product bits are registered.
module fpm (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in1,
  input  logic        additional1,
  input  logic [31:0] in2,
  input  logic        additional2,
  output logic [31:0] out,
  output logic        additionalOut
);

  localparam int NPP = 17;

  // 3:2 compressor over a 64-bit slice: sum bits
  function automatic logic [63:0] csa_sum(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
    csa_sum = a ^ b ^ c;
  endfunction

  // 3:2 compressor over a 64-bit slice: carry bits, already weighted by two
  function automatic logic [63:0] csa_carry(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
    csa_carry = ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic [63:0] mcand_s;
  logic [34:0] mplr_ext_s;
  logic [63:0] pp_s [NPP];
  logic [63:0] sum_s;
  logic [63:0] carry_s;
  logic [63:0] prod_s;
  logic [31:0] prod_d, prod_q;
  logic        side_d, side_q;

  // Multiplier is sign-extended two bits so the 17th group recodes the sign to zero
  assign mcand_s    = {{32{in1[31]}}, in1};
  assign mplr_ext_s = {in2[31], in2[31], in2, 1'b0};

  // Booth recoding of each overlapping 3-bit group into a shifted partial product
  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      logic [63:0] mult;
      mult = 64'd0;
      case (mplr_ext_s[2*i+2 -: 3])
        3'b000, 3'b111: mult = 64'd0;
        3'b001, 3'b010: mult = mcand_s;
        3'b011:         mult = mcand_s << 1;
        3'b100:         mult = ~(mcand_s << 1) + 64'd1;
        3'b101, 3'b110: mult = ~mcand_s + 64'd1;
        default:        mult = 64'd0;
      endcase
      pp_s[i] = mult << (2 * i);
    end
  end

  // Carry-save reduction of all partial products, then one carry-propagate add
  always_comb begin
    sum_s   = pp_s[0];
    carry_s = pp_s[1];
    for (int i = 2; i < NPP; i++) begin
      logic [63:0] s_tmp;
      s_tmp   = csa_sum(sum_s, carry_s, pp_s[i]);
      carry_s = csa_carry(sum_s, carry_s, pp_s[i]);
      sum_s   = s_tmp;
    end
    prod_s = sum_s + carry_s;
  end

  assign prod_d = prod_s[31:0];
  assign side_d = additional1 ^ additional2;

  // Result and sideband registers; reset clears both immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= 32'h0000_0000;
      side_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      side_q <= side_d;
    end
  end

  assign out           = prod_q;
  assign additionalOut = side_q;

endmodule

// File: tb/tb_fpm.sv
// Directed self-checking bench for fpm: reset, sign cases, corners, sideband,
// back-to-back streaming, asynchronous reset mid-stream and a short random sweep.
module tb_fpm;

  logic        clk;
  logic        rst;
  logic [31:0] in1, in2;
  logic        additional1, additional2;
  logic [31:0] out;
  logic        additionalOut;

  int checks_q;
  int errors_q;

  fpm dut (
    .clk           (clk),
    .rst           (rst),
    .in1           (in1),
    .additional1   (additional1),
    .in2           (in2),
    .additional2   (additional2),
    .out           (out),
    .additionalOut (additionalOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a pair, hold it for 'hold' edges and check the product after each edge
  task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int hold);
    in1 = a;
    in2 = b;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check(tag, out, exp);
    end
  endtask

  logic [31:0] stream_a [6] = '{32'd3, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h1234_5678,
                                32'h7FFF_FFFF, 32'h8000_0000};
  logic [31:0] stream_b [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0010,
                                32'h7FFF_FFFF, 32'h8000_0000};
  logic [31:0] stream_e [6] = '{32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFE_0001, 32'h2345_6780,
                                32'h0000_0001, 32'h0000_0000};

  initial begin
    logic [31:0] prev;
    logic [31:0] ra, rb;
    checks_q = 0;
    errors_q = 0;
    rst = 1'b1;
    in1 = 'x;
    in2 = 'x;
    additional1 = 1'bx;
    additional2 = 1'bx;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 32'h0);
    check("reset_side", {31'd0, additionalOut}, 32'h0);

    additional1 = 1'b0;
    additional2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    mul("5x-3", 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF1, 2);
    mul("8x2", 32'd8, 32'd2, 32'd16, 2);
    mul("-4x-3", 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'd12, 2);
    mul("-6x7", 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFD6, 2);
    mul("9x-2", 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFEE, 2);
    mul("-7x4", 32'hFFFF_FFF9, 32'd4, 32'hFFFF_FFE4, 2);
    mul("-5x0", 32'hFFFF_FFFB, 32'd0, 32'h0, 1);
    mul("0x-5", 32'd0, 32'hFFFF_FFFB, 32'h0, 1);
    mul("ident", 32'h0003_5AAB, 32'd1, 32'h0003_5AAB, 1);
    mul("maxx2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1);
    mul("minx-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    mul("2^16sq", 32'h0001_0000, 32'h0001_0000, 32'h0, 1);

    // Sideband XOR, product must stay put while flags toggle or go unknown
    in1 = 32'd6;
    in2 = 32'd7;
    additional1 = 1'b1;
    additional2 = 1'b0;
    @(posedge clk);
    #1;
    check("side_10", {31'd0, additionalOut}, 32'd1);
    check("side_10_out", out, 32'd42);
    additional1 = 1'b1;
    additional2 = 1'b1;
    @(posedge clk);
    #1;
    check("side_11", {31'd0, additionalOut}, 32'd0);
    check("side_11_out", out, 32'd42);
    additional1 = 1'b0;
    additional2 = 1'b1;
    @(posedge clk);
    #1;
    check("side_01", {31'd0, additionalOut}, 32'd1);
    additional1 = 1'bx;
    additional2 = 1'bz;
    @(posedge clk);
    #1;
    check("side_x_out", out, 32'd42);
    additional1 = 1'b0;
    additional2 = 1'b0;

    // Back-to-back: new pair each cycle, old result must hold until the next edge
    prev = out;
    for (int i = 0; i < 6; i++) begin
      in1 = stream_a[i];
      in2 = stream_b[i];
      #1;
      check($sformatf("stream_hold%0d", i), out, prev);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d", i), out, stream_e[i]);
      prev = stream_e[i];
    end

    // Asynchronous reset mid-cycle, then resume
    in1 = 32'd100;
    in2 = 32'd3;
    additional1 = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst", out, 32'd300);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", out, 32'h0);
    check("async_rst_side", {31'd0, additionalOut}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    additional1 = 1'b0;
    mul("resume", 32'hFFFF_FFF6, 32'd10, 32'hFFFF_FF9C, 1);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      mul($sformatf("rand%0d", i), ra, rb, 32'($signed(ra) * $signed(rb)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
